// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch-side, data-side and shared-memory signals of mem_arbiter.
// slave: the arbiter's view; master: the requesters/memory environment view.
interface mem_arbiter_if;
  logic        i_req;
  logic [15:0] i_addr;
  logic [15:0] i_rdata;
  logic        i_valid;
  logic        i_stall;

  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_valid;
  logic        d_stall;

  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  modport slave (
    input  i_req, i_addr,
    output i_rdata, i_valid, i_stall,
    input  d_req, d_wr, d_addr, d_wdata,
    output d_rdata, d_valid, d_stall,
    output mem_en, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_rdata, i_valid, i_stall,
    output d_req, d_wr, d_addr, d_wdata,
    input  d_rdata, d_valid, d_stall,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a shared single-port memory. Data side has fixed
// priority over fetch side; each access holds the memory for LATENCY cycles,
// followed by a one-cycle response state that pulses the owner's valid.
module mem_arbiter #(
  parameter int unsigned LATENCY = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, D_ACC, I_ACC, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_wr_q, mem_wr_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic [15:0] i_rdata_q, i_rdata_d;
  logic [15:0] d_rdata_q, d_rdata_d;
  logic        i_valid_q, i_valid_d;
  logic        d_valid_q, d_valid_d;

  // Next-state and registered-output computation for the access FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    mem_en_d    = mem_en_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_valid_d   = 1'b0;
    d_valid_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.d_req) begin
          state_d     = D_ACC;
          owner_d     = 1'b1;
          cnt_d       = CNT_INIT;
          mem_en_d    = 1'b1;
          mem_wr_d    = bus.d_wr;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
        end else if (bus.i_req) begin
          state_d    = I_ACC;
          owner_d    = 1'b0;
          cnt_d      = CNT_INIT;
          mem_en_d   = 1'b1;
          mem_wr_d   = 1'b0;
          mem_addr_d = bus.i_addr;
        end
      end
      D_ACC, I_ACC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d  = RESP;
          mem_en_d = 1'b0;
          mem_wr_d = 1'b0;
          if (owner_q) begin
            d_valid_d = 1'b1;
            if (!mem_wr_q) d_rdata_d = bus.mem_rdata;
          end else begin
            i_valid_d = 1'b1;
            i_rdata_d = bus.mem_rdata;
          end
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_valid_q   <= i_valid_d;
      d_valid_q   <= d_valid_d;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.i_valid   = i_valid_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.i_stall   = bus.i_req & ~i_valid_q;
  assign bus.d_stall   = bus.d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: one LATENCY=4 instance and one LATENCY=1
// instance. Stimulus pushes expected {rdata, valid cycle}; a monitor pops and
// compares whenever a valid pulse appears.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if bus4 ();
  mem_arbiter_if bus1 ();

  mem_arbiter #(.LATENCY(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  mem_arbiter #(.LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Memory contents seen by the arbiter.
  function automatic logic [15:0] mem_model(input logic [15:0] a);
    case (a)
      16'h0010: return 16'hA5A5;
      16'h0200: return 16'h1111;
      16'h0202: return 16'h2222;
      16'h0004: return 16'hBEEF;
      default:  return a ^ 16'h5A5A;
    endcase
  endfunction

  assign bus4.mem_rdata = mem_model(bus4.mem_addr);
  assign bus1.mem_rdata = mem_model(bus1.mem_addr);

  typedef struct {
    logic [15:0] data;
    int          vcyc;
  } exp_t;

  exp_t q4i[$];
  exp_t q4d[$];
  exp_t q1i[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every valid pulse must match the oldest expectation for its side.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus4.i_valid) begin
        if (q4i.size() == 0) check("i4_unexpected_valid", 1, 0);
        else begin
          e = q4i.pop_front();
          check("i4_rdata", {16'h0, bus4.i_rdata}, {16'h0, e.data});
          check("i4_valid_cycle", cyc, e.vcyc);
        end
      end
      if (bus4.d_valid) begin
        if (q4d.size() == 0) check("d4_unexpected_valid", 1, 0);
        else begin
          e = q4d.pop_front();
          check("d4_rdata", {16'h0, bus4.d_rdata}, {16'h0, e.data});
          check("d4_valid_cycle", cyc, e.vcyc);
        end
      end
      if (bus1.i_valid) begin
        if (q1i.size() == 0) check("i1_unexpected_valid", 1, 0);
        else begin
          e = q1i.pop_front();
          check("i1_rdata", {16'h0, bus1.i_rdata}, {16'h0, e.data});
          check("i1_valid_cycle", cyc, e.vcyc);
        end
      end
      if (bus1.d_valid) check("d1_unexpected_valid", 1, 0);
    end
  end

  // Bounded wait for a valid pulse; returns at the negedge where it is seen.
  task automatic wait_valid(input int which, input int bound);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < bound && !seen; k++) begin
      @(negedge clk);
      case (which)
        0:       seen = bus4.i_valid;
        1:       seen = bus4.d_valid;
        default: seen = bus1.i_valid;
      endcase
    end
    check("valid_timeout", {31'h0, seen}, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    bus4.i_req = 0; bus4.i_addr = '0; bus4.d_req = 0; bus4.d_wr = 0;
    bus4.d_addr = '0; bus4.d_wdata = '0;
    bus1.i_req = 0; bus1.i_addr = '0; bus1.d_req = 0; bus1.d_wr = 0;
    bus1.d_addr = '0; bus1.d_wdata = '0;

    // Reset held with random inputs: outputs zero, stall follows req.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus4.i_req   = 1'($urandom);
      bus4.d_req   = 1'($urandom);
      bus4.d_wr    = 1'($urandom);
      bus4.i_addr  = 16'($urandom);
      bus4.d_addr  = 16'($urandom);
      bus4.d_wdata = 16'($urandom);
      #1;
      check("rst_mem_ctl", {30'h0, bus4.mem_en, bus4.mem_wr}, 0);
      check("rst_mem_addr_wdata", {bus4.mem_addr, bus4.mem_wdata}, 0);
      check("rst_rdata", {bus4.i_rdata, bus4.d_rdata}, 0);
      check("rst_valid", {30'h0, bus4.i_valid, bus4.d_valid}, 0);
      check("rst_stall", {30'h0, bus4.i_stall, bus4.d_stall},
            {30'h0, bus4.i_req, bus4.d_req});
    end
    @(negedge clk);
    bus4.i_req = 0; bus4.d_req = 0; bus4.d_wr = 0;
    bus4.i_addr = '0; bus4.d_addr = '0; bus4.d_wdata = '0;
    @(negedge clk);
    rst = 1'b0;

    // Single fetch read.
    @(negedge clk);
    bus4.i_req = 1; bus4.i_addr = 16'h0010;
    g = cyc + 1;
    q4i.push_back('{16'hA5A5, g + 4});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("i_read_mem_en", {31'h0, bus4.mem_en}, {31'h0, (k < 4)});
      if (k < 4) check("i_read_mem_addr", {16'h0, bus4.mem_addr}, 32'h0010);
      check("i_read_stall", {31'h0, bus4.i_stall}, {31'h0, (k != 4)});
    end
    bus4.i_req = 0;

    // Simultaneous requests: data write wins, fetch waits.
    @(negedge clk);
    bus4.d_req = 1; bus4.d_wr = 1; bus4.d_addr = 16'h0100; bus4.d_wdata = 16'h1234;
    bus4.i_req = 1; bus4.i_addr = 16'h0020;
    g = cyc + 1;
    q4d.push_back('{16'h0000, g + 4});
    q4i.push_back('{16'h5A7A, g + 10});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("d_wr_mem_ctl", {30'h0, bus4.mem_en, bus4.mem_wr}, 32'h3);
      check("d_wr_mem_addr_wdata", {bus4.mem_addr, bus4.mem_wdata}, 32'h0100_1234);
      check("d_wr_i_stall", {31'h0, bus4.i_stall}, 1);
    end
    wait_valid(1, 4);
    bus4.d_req = 0; bus4.d_wr = 0;
    wait_valid(0, 10);
    bus4.i_req = 0;

    // Back-to-back data reads; req held through RESP must not double-grant.
    @(negedge clk);
    bus4.d_req = 1; bus4.d_addr = 16'h0200;
    g = cyc + 1;
    q4d.push_back('{16'h1111, g + 4});
    q4d.push_back('{16'h2222, g + 10});
    wait_valid(1, 8);
    bus4.d_addr = 16'h0202;
    @(negedge clk);
    check("b2b_resp_gap_mem_en", {31'h0, bus4.mem_en}, 0);
    wait_valid(1, 10);
    bus4.d_req = 0;
    repeat (3) begin
      @(negedge clk);
      check("b2b_no_dup_grant", {31'h0, bus4.mem_en}, 0);
    end
    check("d_rdata_hold", {16'h0, bus4.d_rdata}, 32'h2222);

    // Reset in the middle of a data access.
    @(negedge clk);
    bus4.d_req = 1; bus4.d_addr = 16'h0300;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_mem_en", {31'h0, bus4.mem_en}, 1);
    #2 rst = 1'b1;
    #1 check("async_rst_mem_en", {31'h0, bus4.mem_en}, 0);
    bus4.d_req = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus4.i_req = 1; bus4.i_addr = 16'h0040;
    g = cyc + 1;
    q4i.push_back('{16'h5A1A, g + 4});
    wait_valid(0, 8);
    bus4.i_req = 0;
    check("post_rst_d_rdata", {16'h0, bus4.d_rdata}, 0);

    // LATENCY=1 instance.
    @(negedge clk);
    bus1.i_req = 1; bus1.i_addr = 16'h0004;
    g = cyc + 1;
    q1i.push_back('{16'hBEEF, g + 1});
    @(negedge clk);
    check("lat1_mem_en", {31'h0, bus1.mem_en}, 1);
    check("lat1_mem_addr", {16'h0, bus1.mem_addr}, 32'h0004);
    wait_valid(2, 4);
    check("lat1_mem_en_off", {31'h0, bus1.mem_en}, 0);
    bus1.i_req = 0;

    repeat (5) @(negedge clk);
    check("scoreboard_drained", q4i.size() + q4d.size() + q1i.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
